// File: rtl/iter_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package iter_divider_pkg;

    localparam int unsigned DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    // Bits needed to hold values 0..value-1 (at least 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned w;
        v = value - 1;
        w = 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import iter_divider_pkg::*;
#(
    parameter int unsigned N = DIV_WIDTH
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] rem_o,
    output logic         qbit_o
);

    logic [N:0] trial;
    logic [N:0] divisor_ext;

    // Full-width trial keeps the compare exact even when rem has its MSB set.
    always_comb begin
        trial       = {rem_i, bit_i};
        divisor_ext = {1'b0, divisor_i};
        qbit_o      = (trial >= divisor_ext);
        rem_o       = qbit_o ? N'(trial - divisor_ext) : trial[N-1:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider with start/done handshake, one quotient bit per cycle.
// Optional two's-complement operands when ITER_DIVIDER_SIGNED_EN is defined.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int unsigned n = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         ready,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = clog2(n);

    div_state_t      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [n-1:0]    rem_q, rem_d;
    logic [n-1:0]    work_q, work_d;
    logic [n-1:0]    dvs_q, dvs_d;
    logic [n-1:0]    quo_q, quo_d;
    logic [n-1:0]    rmd_q, rmd_d;
    logic            dbz_q, dbz_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;

    logic [n-1:0]    step_rem;
    logic            step_qbit;
    logic [n-1:0]    step_quo;

`ifdef ITER_DIVIDER_SIGNED_EN
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [n-1:0]    dividend_mag;
    logic [n-1:0]    divisor_mag;

    assign dividend_mag = dividend[n-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[n-1]  ? -divisor  : divisor;
`endif

    div_step #(.N(n)) u_step (
        .rem_i     (rem_q),
        .bit_i     (work_q[n-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // Dividend bits shift out of the top while quotient bits fill in from the bottom.
    assign step_quo = {work_q[n-2:0], step_qbit};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        work_d  = work_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
`ifdef ITER_DIVIDER_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif

        case (state_q)
            IDLE: begin
                if (start && ready_q) begin
                    if (divisor == '0) begin
                        state_d = FINISH;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        count_d = CW'(n - 1);
                        rem_d   = '0;
`ifdef ITER_DIVIDER_SIGNED_EN
                        work_d  = dividend_mag;
                        dvs_d   = divisor_mag;
                        qneg_d  = dividend[n-1] ^ divisor[n-1];
                        rneg_d  = dividend[n-1];
`else
                        work_d  = dividend;
                        dvs_d   = divisor;
`endif
                    end
                end
            end
            RUN: begin
                rem_d  = step_rem;
                work_d = step_quo;
                if (count_q == '0) begin
                    // Results land as FINISH is entered so they are valid alongside done.
                    state_d = FINISH;
                    done_d  = 1'b1;
                    dbz_d   = 1'b0;
`ifdef ITER_DIVIDER_SIGNED_EN
                    quo_d   = qneg_q ? -step_quo : step_quo;
                    rmd_d   = rneg_q ? -step_rem : step_rem;
`else
                    quo_d   = step_quo;
                    rmd_d   = step_rem;
`endif
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            work_q  <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef ITER_DIVIDER_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            ready_q <= ready_d;
`ifdef ITER_DIVIDER_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider (n = 16).
module tb_iter_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        ready;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    iter_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at 1ns after a rising edge while idle; returns in the done cycle.
    // lat = 1 means done is visible in the cycle right after the accepting edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (quotient !== 16'h0000) begin errors++; $display("FAIL reset_quotient: got %h expected 0000", quotient); end
        checks++; if (remainder !== 16'h0000) begin errors++; $display("FAIL reset_remainder: got %h expected 0000", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    endtask

    task automatic test_basic;
        int lat;
        run_op(16'd100, 16'd7, lat);
        checks++; if (lat !== 17) begin errors++; $display("FAIL basic_latency: got %0d expected 17", lat); end
        checks++; if (quotient !== 16'd14) begin errors++; $display("FAIL basic_quotient: got %0d expected 14", quotient); end
        checks++; if (remainder !== 16'd2) begin errors++; $display("FAIL basic_remainder: got %0d expected 2", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_finish: got %b expected 0", ready); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b expected 1", ready); end
    endtask

    task automatic test_extremes;
        int lat;
        run_op(16'hFFFF, 16'h0001, lat);
        checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL max_by_one_quotient: got %h expected ffff", quotient); end
        checks++; if (remainder !== 16'h0000) begin errors++; $display("FAIL max_by_one_remainder: got %h expected 0000", remainder); end
        @(posedge clk); #1;
        run_op(16'd5, 16'd9, lat);
        checks++; if (quotient !== 16'd0) begin errors++; $display("FAIL small_quotient: got %0d expected 0", quotient); end
        checks++; if (remainder !== 16'd5) begin errors++; $display("FAIL small_remainder: got %0d expected 5", remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero;
        int lat;
        run_op(16'h1234, 16'h0000, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL dz_quotient: got %h expected ffff", quotient); end
        checks++; if (remainder !== 16'h1234) begin errors++; $display("FAIL dz_remainder: got %h expected 1234", remainder); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
        @(posedge clk); #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL dz_ready_after: got %b expected 1", ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (div_by_zero !== 1'b1 || quotient !== 16'hFFFF) begin errors++; $display("FAIL dz_hold: got dbz=%b q=%h expected dbz=1 q=ffff", div_by_zero, quotient); end
    endtask

    task automatic test_ignore_start;
        int lat;
        int extra;
        start = 1'b1; dividend = 16'd200; divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 64) begin
            if (lat == 3 || lat == 10) begin
                start = 1'b1; dividend = 16'd999; divisor = 16'd4;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        checks++; if (lat !== 17) begin errors++; $display("FAIL ignore_latency: got %0d expected 17", lat); end
        checks++; if (quotient !== 16'd66) begin errors++; $display("FAIL ignore_quotient: got %0d expected 66", quotient); end
        checks++; if (remainder !== 16'd2) begin errors++; $display("FAIL ignore_remainder: got %0d expected 2", remainder); end
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_extra_done: got %0d expected 0", extra); end
        checks++; if (quotient !== 16'd66 || remainder !== 16'd2) begin errors++; $display("FAIL ignore_hold: got q=%0d r=%0d expected q=66 r=2", quotient, remainder); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int pulses;
        start = 1'b1; dividend = 16'd100; divisor = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready); end
        checks++; if (quotient !== 16'd0 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got q=%h r=%h dbz=%b expected all 0", quotient, remainder, div_by_zero); end
        pulses = 0;
        repeat (20) begin
            if (done === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", pulses); end
        run_op(16'd50, 16'd5, lat);
        checks++; if (quotient !== 16'd10 || remainder !== 16'd0) begin errors++; $display("FAIL midrst_fresh: got q=%0d r=%0d expected q=10 r=0", quotient, remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_and_start;
        rst = 1'b1; start = 1'b1; dividend = 16'd9; divisor = 16'd3;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        checks++; if (ready !== 1'b1 || quotient !== 16'd0) begin errors++; $display("FAIL rst_wins: got ready=%b q=%h expected ready=1 q=0000", ready, quotient); end
    endtask

    task automatic test_back_to_back;
        int t;
        int first;
        int second;
        t = 0; first = -1; second = -1;
        start = 1'b1; dividend = 16'd1000; divisor = 16'd10;
        while (second < 0 && t < 80) begin
            @(posedge clk); #1;
            t++;
            if (done === 1'b1) begin
                if (first < 0) first = t;
                else second = t;
            end
        end
        start = 1'b0;
        checks++; if (first !== 17) begin errors++; $display("FAIL b2b_first: got %0d expected 17", first); end
        checks++; if (second - first !== 18) begin errors++; $display("FAIL b2b_spacing: got %0d expected 18", second - first); end
        checks++; if (quotient !== 16'd100 || remainder !== 16'd0) begin errors++; $display("FAIL b2b_result: got q=%0d r=%0d expected q=100 r=0", quotient, remainder); end
        @(posedge clk); #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", ready); end
    endtask

`ifdef ITER_DIVIDER_SIGNED_EN
    task automatic test_signed;
        int lat;
        run_op(16'hFFF9, 16'h0002, lat);
        checks++; if (quotient !== 16'hFFFD || remainder !== 16'hFFFF) begin errors++; $display("FAIL s_neg7_by_2: got q=%h r=%h expected q=fffd r=ffff", quotient, remainder); end
        @(posedge clk); #1;
        run_op(16'h0007, 16'hFFFE, lat);
        checks++; if (quotient !== 16'hFFFD || remainder !== 16'h0001) begin errors++; $display("FAIL s_7_by_neg2: got q=%h r=%h expected q=fffd r=0001", quotient, remainder); end
        @(posedge clk); #1;
        run_op(16'h8000, 16'hFFFF, lat);
        checks++; if (quotient !== 16'h8000 || remainder !== 16'h0000 || div_by_zero !== 1'b0) begin errors++; $display("FAIL s_overflow: got q=%h r=%h dbz=%b expected q=8000 r=0000 dbz=0", quotient, remainder, div_by_zero); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL s_latency: got %0d expected 17", lat); end
        @(posedge clk); #1;
        run_op(16'hFF9C, 16'hFFF9, lat);
        checks++; if (quotient !== 16'h000E || remainder !== 16'hFFFE) begin errors++; $display("FAIL s_neg100_by_neg7: got q=%h r=%h expected q=000e r=fffe", quotient, remainder); end
        @(posedge clk); #1;
    endtask
`else
    task automatic test_unsigned_wide;
        int lat;
        run_op(16'hFFFF, 16'hFFFF, lat);
        checks++; if (quotient !== 16'h0001 || remainder !== 16'h0000) begin errors++; $display("FAIL u_equal: got q=%h r=%h expected q=0001 r=0000", quotient, remainder); end
        @(posedge clk); #1;
        run_op(16'h8000, 16'hC000, lat);
        checks++; if (quotient !== 16'h0000 || remainder !== 16'h8000) begin errors++; $display("FAIL u_big_divisor: got q=%h r=%h expected q=0000 r=8000", quotient, remainder); end
        @(posedge clk); #1;
        run_op(16'hABCD, 16'h0100, lat);
        checks++; if (quotient !== 16'h00AB || remainder !== 16'h00CD) begin errors++; $display("FAIL u_shift: got q=%h r=%h expected q=00ab r=00cd", quotient, remainder); end
        @(posedge clk); #1;
        run_op(16'hFFFF, 16'h8001, lat);
        checks++; if (quotient !== 16'h0001 || remainder !== 16'h7FFE) begin errors++; $display("FAIL u_msb_rem: got q=%h r=%h expected q=0001 r=7ffe", quotient, remainder); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_rst_and_start();
        test_back_to_back();
`ifdef ITER_DIVIDER_SIGNED_EN
        test_signed();
`else
        test_unsigned_wide();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
